// File: rtl/adma_desc_fetch.sv
// adma_desc_fetch: reads one 32-byte chain descriptor (4 x 64-bit beats) over the WB master
// and hands the unpacked fields to the ADMA engine with a valid/ready handshake.
// Build option: define ADMA_DESC_BURST_EN to hold cyc/stb across all four beats with cab=1;
// left undefined, each beat is a separate cycle with a one-cycle GAP in between and cab=0.
module adma_desc_fetch #(
    parameter int MAX_RTY = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        start_i,
    input  logic [31:0] ndar_i,
    output logic [31:0] wbm_adr_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic        wbm_cab_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    input  logic [31:0] wbm_dat_i,
    input  logic [31:0] wbm_dat64_i,
    output logic        desc_valid_o,
    input  logic        desc_ready_i,
    output logic [31:0] next_desc_o,
    output logic [31:0] ctl_addr_o,
    output logic [31:0] dc_fc_o,
    output logic [31:0] src_desc_o,
    output logic [31:0] dst_desc_o,
    output logic        busy_o,
    output logic        err_o
);
`ifdef ADMA_DESC_BURST_EN
    localparam logic BURST = 1'b1;
`else
    localparam logic BURST = 1'b0;
`endif
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CHK  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;
    localparam int RW = $clog2(MAX_RTY + 2);

    logic [2:0]    state, nxt;
    logic [1:0]    beat, beat_n;
    logic [RW-1:0] rty_cnt, rty_n;
    logic [31:0]   ndar_q;
    logic          beat_done;

    assign wbm_we_o  = 1'b0;
    assign beat_done = state == S_RD && wbm_ack_i && !wbm_err_i && !wbm_rty_i;

    // next state, beat index and retry count; bus error beats retry, retry beats ack
    always_comb begin
        nxt    = state;
        beat_n = beat;
        rty_n  = rty_cnt;
        case (state)
            S_IDLE: nxt = start_i ? S_CHK : S_IDLE;
            S_CHK: begin
                nxt    = |ndar_q[4:0] ? S_ERR : S_RD;
                beat_n = 2'd0;
                rty_n  = '0;
            end
            S_RD: begin
                if (wbm_err_i) begin
                    nxt = S_ERR;
                end else if (wbm_rty_i) begin
                    if (rty_cnt == RW'(MAX_RTY)) nxt = S_ERR;
                    else rty_n = rty_cnt + 1'b1;
                end else if (wbm_ack_i) begin
                    rty_n = '0;
                    if (beat == 2'd3) begin
                        nxt = S_HOLD;
                    end else begin
                        beat_n = beat + 2'd1;
                        nxt    = BURST ? S_RD : S_GAP;
                    end
                end
            end
            S_GAP:  nxt = S_RD;
            S_HOLD: nxt = desc_ready_i ? S_IDLE : S_HOLD;
            S_ERR:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // state and all bus/status outputs registered from the next state so they change on the edge
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state        <= S_IDLE;
            beat         <= 2'd0;
            rty_cnt      <= '0;
            ndar_q       <= 32'd0;
            wbm_adr_o    <= 32'd0;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            wbm_cab_o    <= 1'b0;
            wbm_sel_o    <= 4'd0;
            desc_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state        <= nxt;
            beat         <= beat_n;
            rty_cnt      <= rty_n;
            if (state == S_IDLE && start_i) ndar_q <= ndar_i;
            wbm_adr_o    <= nxt == S_RD ? ndar_q + {27'd0, beat_n, 3'b000} : 32'd0;
            wbm_cyc_o    <= nxt == S_RD;
            wbm_stb_o    <= nxt == S_RD;
            wbm_cab_o    <= BURST && nxt == S_RD;
            wbm_sel_o    <= {4{nxt == S_RD}};
            desc_valid_o <= nxt == S_HOLD;
            busy_o       <= nxt != S_IDLE;
            err_o        <= nxt == S_ERR;
        end
    end

    // unpack each accepted beat into its descriptor fields; low words of beats 1-3 are unused
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            next_desc_o <= 32'd0;
            ctl_addr_o  <= 32'd0;
            dc_fc_o     <= 32'd0;
            src_desc_o  <= 32'd0;
            dst_desc_o  <= 32'd0;
        end else if (beat_done) begin
            case (beat)
                2'd0: begin
                    next_desc_o <= wbm_dat64_i;
                    ctl_addr_o  <= wbm_dat_i;
                end
                2'd1: dc_fc_o    <= wbm_dat64_i;
                2'd2: src_desc_o <= wbm_dat64_i;
                default: dst_desc_o <= wbm_dat64_i;
            endcase
        end
    end
endmodule

// File: tb/tb_adma_desc_fetch.sv
// tb_adma_desc_fetch: directed bench for adma_desc_fetch; honours ADMA_DESC_BURST_EN like the RTL.
module tb_adma_desc_fetch;
`ifdef ADMA_DESC_BURST_EN
    localparam logic BURST = 1'b1;
    localparam int   LAT   = 6;
`else
    localparam logic BURST = 1'b0;
    localparam int   LAT   = 9;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, ready = 1'b0, clr = 1'b0, err_en = 1'b0;
    logic [31:0] ndar = 32'd0, err_adr = 32'd0, rty_adr = 32'd8;
    int rty_lim = 0;
    logic [31:0] adr, dat, dat64, next_desc, ctl_addr, dc_fc, src_desc, dst_desc;
    logic cyc, stb, we, cab, ack, err, rty, valid, busy, err_o;
    logic [3:0] sel;
    logic [31:0] mem_h [0:511];
    logic [31:0] mem_l [0:511];
    int rty_seen = 0, adr8_cnt = 0, err_cnt = 0, valid_cnt = 0, cyc_cnt = 0, s818 = 0, proto_bad = 0;
    logic [31:0] hq[$];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    assign ack   = cyc;
    assign rty   = cyc && adr == rty_adr && rty_seen < rty_lim;
    assign err   = err_en && cyc && adr == err_adr;
    assign dat64 = mem_h[adr[11:3]];
    assign dat   = mem_l[adr[11:3]];

    adma_desc_fetch dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .start_i(start), .ndar_i(ndar),
        .wbm_adr_o(adr), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_cab_o(cab),
        .wbm_sel_o(sel), .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty),
        .wbm_dat_i(dat), .wbm_dat64_i(dat64), .desc_valid_o(valid), .desc_ready_i(ready),
        .next_desc_o(next_desc), .ctl_addr_o(ctl_addr), .dc_fc_o(dc_fc),
        .src_desc_o(src_desc), .dst_desc_o(dst_desc), .busy_o(busy), .err_o(err_o)
    );

    // bus monitor: counts events per test (cleared by clr) and flags protocol violations
    always @(posedge clk) begin
        if (rst_n && (stb !== cyc || we !== 1'b0 || cab !== (BURST & cyc) || (cyc && sel !== 4'hF)))
            proto_bad <= proto_bad + 1;
        if (clr) begin
            rty_seen <= 0; adr8_cnt <= 0; err_cnt <= 0; valid_cnt <= 0; cyc_cnt <= 0; s818 <= 0;
            hq.delete();
        end else begin
            if (rty) rty_seen <= rty_seen + 1;
            if (cyc && stb && adr == 32'h8) adr8_cnt <= adr8_cnt + 1;
            if (cyc && adr == 32'h818) s818 <= s818 + 1;
            if (cyc) cyc_cnt <= cyc_cnt + 1;
            if (err_o) err_cnt <= err_cnt + 1;
            if (valid) valid_cnt <= valid_cnt + 1;
            if (cyc && ack && !rty && !err) hq.push_back(adr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // pulse start and wait (bounded) for desc_valid; lat counts edges from the drive edge
    task automatic fetch(input logic [31:0] a, output int lat);
        start = 1'b1;
        ndar  = a;
        tick();
        start = 1'b0;
        lat = 1;
        while (!valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_desc();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, "_next"}, next_desc, 32'h300);
        chk({tag, "_ctl"}, ctl_addr, 32'h200);
        chk({tag, "_dcfc"}, dc_fc, 32'h1);
        chk({tag, "_src"}, src_desc, 32'h400);
        chk({tag, "_dst"}, dst_desc, 32'h500);
    endtask

    initial begin
        int n, stable;
        for (int i = 0; i < 512; i++) begin
            mem_h[i] = 32'd0;
            mem_l[i] = 32'd0;
        end
        mem_h[0] = 32'h300; mem_l[0] = 32'h200;
        mem_h[1] = 32'h1;
        mem_h[2] = 32'h400;
        mem_h[3] = 32'h500;
        mem_h[9'h100] = 32'hA00; mem_l[9'h100] = 32'hB00;
        mem_h[9'h101] = 32'h7;
        mem_h[9'h102] = 32'hCCC;
        mem_h[9'h103] = 32'hDDD;
        tick(2);
        chk("rst_cyc", {31'd0, cyc}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_next", next_desc, 32'd0);
        rst_n = 1'b1;
        tick();
        clear();

        // 1: basic fetch with cycle-accurate start-up and latency
        start = 1'b1; ndar = 32'd0;
        tick();
        start = 1'b0;
        chk("t1_chk_busy", {31'd0, busy}, 32'd1);
        chk("t1_chk_cyc", {31'd0, cyc}, 32'd0);
        tick();
        chk("t1_rd_cyc", {31'd0, cyc}, 32'd1);
        chk("t1_rd_adr", adr, 32'd0);
        chk("t1_rd_cab", {31'd0, cab}, {31'd0, BURST});
        tick();
        chk("t1_gap_cyc", {31'd0, cyc}, {31'd0, BURST});
        n = 3;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
        chk("t1_lat", n, LAT);
        chk("t1_nbeats", hq.size(), 4);
        for (int i = 0; i < 4 && i < hq.size(); i++) chk("t1_adr", hq[i], 32'(8 * i));
        chk_fields("t1");

        // 2: backpressure
        stable = 0;
        repeat (10) begin
            tick();
            if (valid && next_desc == 32'h300 && ctl_addr == 32'h200 && dst_desc == 32'h500) stable++;
        end
        chk("t2_stable", stable, 10);
        chk("t2_busy_hold", {31'd0, busy}, 32'd1);
        release_desc();
        chk("t2_valid_drop", {31'd0, valid}, 32'd0);
        chk("t2_busy_drop", {31'd0, busy}, 32'd0);

        // 3: misaligned start, then a clean fetch
        clear();
        start = 1'b1; ndar = 32'h208;
        tick();
        start = 1'b0;
        tick(5);
        chk("t3_cyc_cnt", cyc_cnt, 0);
        chk("t3_err_cnt", err_cnt, 1);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_valid_cnt", valid_cnt, 0);
        fetch(32'd0, n);
        chk("t3_lat", n, LAT);
        chk_fields("t3");
        release_desc();

        // 4a: two retries on beat1, then ack
        clear();
        rty_lim = 2;
        fetch(32'd0, n);
        chk("t4_adr8_cnt", adr8_cnt, 3);
        chk("t4_lat", n, LAT + 2);
        chk_fields("t4");
        release_desc();
        // 4b: five retries exceed MAX_RTY
        clear();
        rty_lim = 5;
        fetch(32'd0, n);
        chk("t4b_err_cnt", err_cnt, 1);
        chk("t4b_valid_cnt", valid_cnt, 0);
        chk("t4b_rty_seen", rty_seen, 5);
        chk("t4b_busy", {31'd0, busy}, 32'd0);
        rty_lim = 0;

        // 5: bus error on beat2 at 0x800
        clear();
        err_en = 1'b1; err_adr = 32'h810;
        fetch(32'h800, n);
        err_en = 1'b0;
        chk("t5_err_cnt", err_cnt, 1);
        chk("t5_s818", s818, 0);
        chk("t5_cyc", {31'd0, cyc}, 32'd0);
        chk("t5_valid_cnt", valid_cnt, 0);
        chk("t5_dcfc", dc_fc, 32'h7);

        // 6: asynchronous reset mid-beat1, then clean fetch
        clear();
        start = 1'b1; ndar = 32'd0;
        tick();
        start = 1'b0;
        n = 0;
        while (!(cyc && adr == 32'h8) && n < 40) begin
            tick();
            n++;
        end
        chk("t6_reach_beat1", {31'd0, cyc && adr == 32'h8}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_cyc", {31'd0, cyc}, 32'd0);
        chk("t6_stb", {31'd0, stb}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_adr", adr, 32'd0);
        chk("t6_next", next_desc, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        fetch(32'd0, n);
        chk("t6_lat", n, LAT);
        chk_fields("t6");
        release_desc();
        chk("proto", proto_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
